// File: rtl/sio_remote_if.sv
// Local-side bus of the SIO remote: frame delivery, read request and response word.
interface sio_remote_if #(
  parameter int unsigned NBT = 40,
  parameter int unsigned NBR = 32
);
  logic           wvalid;
  logic [NBT-1:0] wdata;
  logic           rreq;
  logic [NBR-1:0] rdata;
  logic           busy;
  logic [15:0]    err_cnt;

  // master: the remote link block; slave: the local logic it serves
  modport master (output wvalid, wdata, rreq, busy, err_cnt, input rdata);
  modport slave  (input wvalid, wdata, rreq, busy, err_cnt, output rdata);
endinterface

// File: rtl/sio_remote.sv
// Device end of the single-wire SIO link: receives host frames, answers read frames.
// Optional error counter enabled by defining SIO_REMOTE_ERRCNT_EN.
module sio_remote #(
  parameter int unsigned NBT = 40,
  parameter int unsigned NBR = 32,
  parameter int unsigned OVS = 4,
  parameter int unsigned TA  = 10
) (
  input  logic          c,
  input  logic          rn,
  inout  wire           sdio,
  sio_remote_if.master  bus
);

  localparam int unsigned CW = $clog2(TA * OVS);
  localparam int unsigned IW = $clog2((NBT > NBR + 1) ? NBT : NBR + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, WAITHI, TURN, TX, PARK
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [NBT-2:0] shr_q, shr_d;
  logic [NBR:0]   sh_q, sh_d;
  logic [NBT-1:0] wdata_q, wdata_d;
  logic           wvalid_q, wvalid_d;
  logic           rreq_q, rreq_d;
  logic           busy_q, busy_d;
  logic           oe_q, oe_d;
  logic           sync_q, s_q, s_d_q;
  logic [NBT-1:0] frame_c;
  logic           mid_c;

  // Line is driven only while responding; the MSB of the tx shifter is the bit on the wire
  assign sdio = oe_q ? sh_q[NBR] : 1'bz;

  assign frame_c = {shr_q, s_q};
  assign mid_c   = (cnt_q == CW'(OVS - 1));

  // Two-flop synchronizer plus previous sample for falling-edge detection
  always_ff @(posedge c) begin
    if (!rn) begin
      sync_q <= 1'b1;
      s_q    <= 1'b1;
      s_d_q  <= 1'b1;
    end else begin
      sync_q <= sdio;
      s_q    <= sync_q;
      s_d_q  <= s_q;
    end
  end

  // State register
  always_ff @(posedge c) begin
    if (!rn) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!oe_q && s_d_q && !s_q) state_d = START;
      START:  if (cnt_q == CW'(OVS / 2 - 1)) state_d = s_q ? IDLE : DATA;
      DATA:   if (mid_c && (idx_q == IW'(NBT - 1))) state_d = frame_c[NBT-1] ? TURN : WAITHI;
      WAITHI: if (s_q) state_d = IDLE;
      TURN:   if (cnt_q == CW'(TA * OVS - 1)) state_d = TX;
      TX:     if (mid_c && (idx_q == IW'(NBR))) state_d = PARK;
      PARK:   if (mid_c) state_d = WAITHI;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    shr_d    = shr_q;
    sh_d     = sh_q;
    wdata_d  = wdata_q;
    wvalid_d = 1'b0;
    rreq_d   = 1'b0;
    oe_d     = oe_q;
    case (state_q)
      IDLE, WAITHI: cnt_d = '0;
      START: begin
        if (cnt_q == CW'(OVS / 2 - 1)) begin
          cnt_d = '0;
          idx_d = '0;
        end
      end
      DATA: begin
        if (mid_c) begin
          cnt_d = '0;
          shr_d = frame_c[NBT-2:0];
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(NBT - 1)) begin
            wdata_d = frame_c;
            if (frame_c[NBT-1]) rreq_d   = 1'b1;
            else                wvalid_d = 1'b1;
          end
        end
      end
      TURN: begin
        if (cnt_q == CW'(TA * OVS - 1)) begin
          cnt_d = '0;
          idx_d = '0;
          sh_d  = {1'b0, bus.rdata};
          oe_d  = 1'b1;
        end
      end
      TX: begin
        if (mid_c) begin
          cnt_d = '0;
          sh_d  = {sh_q[NBR-1:0], 1'b1};
          idx_d = idx_q + IW'(1);
        end
      end
      PARK: begin
        if (mid_c) begin
          cnt_d = '0;
          oe_d  = 1'b0;
        end
      end
      default: cnt_d = '0;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge c) begin
    if (!rn) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shr_q    <= '0;
      sh_q     <= '1;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
      rreq_q   <= 1'b0;
      busy_q   <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shr_q    <= shr_d;
      sh_q     <= sh_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      rreq_q   <= rreq_d;
      busy_q   <= busy_d;
      oe_q     <= oe_d;
    end
  end

  assign bus.wvalid = wvalid_q;
  assign bus.wdata  = wdata_q;
  assign bus.rreq   = rreq_q;
  assign bus.busy   = busy_q;

`ifdef SIO_REMOTE_ERRCNT_EN
  logic [15:0] err_q;
  logic        err_ev_c;

  // Error events: false start bit, or host driving low during the turnaround window
  always_comb begin
    err_ev_c = ((state_q == START) && (cnt_q == CW'(OVS / 2 - 1)) && s_q) ||
               ((state_q == TURN) && (cnt_q >= CW'(2 * OVS)) && !s_q);
  end

  // Saturating error counter
  always_ff @(posedge c) begin
    if (!rn)                                err_q <= '0;
    else if (err_ev_c && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
  end

  assign bus.err_cnt = err_q;
`else
  assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_sio_remote.sv
// Randomized scoreboard bench for sio_remote: host-side frame driver, rx and tx monitors.
module tb_sio_remote;
  localparam int NBT = 40;
  localparam int NBR = 32;
  localparam int OVS = 4;
  localparam int TA  = 10;
`ifdef SIO_REMOTE_ERRCNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  typedef struct packed {
    logic           rd;
    logic [NBT-1:0] data;
  } exp_ev_t;

  logic c, rn, h_oe, h_val;
  wire  sdio;
  int   n_cmp, n_bad, cyc;
  int   n_wv, n_rreq, n_rise, rreq_cyc, oe_rise_cyc, exp_err;
  exp_ev_t          exp_q[$];
  logic [NBR-1:0]   rsp_q[$];

  assign sdio = h_oe ? h_val : 1'bz;
  pullup (sdio);

  sio_remote_if #(.NBT(NBT), .NBR(NBR)) bus ();

  sio_remote #(.NBT(NBT), .NBR(NBR), .OVS(OVS), .TA(TA)) dut (
    .c    (c),
    .rn   (rn),
    .sdio (sdio),
    .bus  (bus)
  );

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  always @(posedge c) cyc++;

  initial begin
    repeat (60000) @(posedge c);
    $display("FAIL watchdog: cycle limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge c);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    h_oe  = 1'b1;
    h_val = b;
    tick(OVS);
  endtask

  // Reference model: a frame is a read when its MSB is set; the word is delivered unchanged
  task automatic send_frame(input logic [NBT-1:0] f, input int gap_bits);
    exp_ev_t e;
    e.rd   = f[NBT-1];
    e.data = f;
    exp_q.push_back(e);
    if (e.rd) rsp_q.push_back(bus.rdata);
    drive_bit(1'b0);
    for (int i = NBT - 1; i >= 0; i--) drive_bit(f[i]);
    if (e.rd) h_oe = 1'b0;
    else repeat (gap_bits) drive_bit(1'b1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400 && bus.busy; i++) tick(1);
    if (bus.busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", i);
    end
    h_oe  = 1'b1;
    h_val = 1'b1;
  endtask

  task automatic wait_count(input string name, input int which, input int old);
    int i;
    int now;
    now = (which == 0) ? n_rreq : n_rise;
    for (i = 0; i < 200 && now == old; i++) begin
      tick(1);
      now = (which == 0) ? n_rreq : n_rise;
    end
    if (now == old) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event count %0d, required %0d", name, now, old + 1);
    end
  endtask

  // Rx monitor: every wvalid/rreq pulse is matched against the next expected frame
  initial begin : rx_mon
    exp_ev_t e;
    forever begin
      @(negedge c);
      if (rn && (bus.wvalid || bus.rreq)) begin
        chk("pulse_exclusive", 64'(bus.wvalid & bus.rreq), 64'(0));
        if (bus.rreq) begin
          rreq_cyc = cyc;
          n_rreq++;
        end else begin
          n_wv++;
        end
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: got wdata 0x%0h, no frame pending", bus.wdata);
        end else begin
          e = exp_q.pop_front();
          chk("frame_kind_rreq", 64'(bus.rreq), 64'(e.rd));
          chk("wdata", 64'(bus.wdata), 64'(e.data));
        end
      end
    end
  end

  // Tx monitor: on each response, check turnaround delay, mid-bit values, park bit and release
  initial begin : tx_mon
    logic [NBR+1:0] eb;
    logic prev;
    bit   ab;
    prev = 1'b0;
    forever begin
      @(negedge c);
      if (rn && dut.oe_q && !prev) begin
        oe_rise_cyc = cyc;
        n_rise++;
        chk("turnaround_clocks", 64'(cyc - rreq_cyc), 64'(TA * OVS));
        if (rsp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_response: oe rose at cycle %0d with no read pending", cyc);
          eb = '1;
        end else begin
          eb = {1'b0, rsp_q.pop_front(), 1'b1};
        end
        ab = 1'b0;
        for (int i = 0; i < (NBR + 2) * OVS; i++) begin
          if (i != 0) @(negedge c);
          if (!rn) begin
            ab = 1'b1;
            break;
          end
          if (i % OVS == OVS / 2)
            chk($sformatf("tx_bit%0d_{sdio,oe}", i / OVS), 64'({sdio, dut.oe_q}),
                64'({eb[NBR + 1 - i / OVS], 1'b1}));
        end
        if (!ab) begin
          @(negedge c);
          chk("oe_release", 64'(dut.oe_q), 64'(0));
        end
      end
      prev = dut.oe_q;
    end
  end

  initial begin : main
    logic [NBT-1:0] f;
    int k;
    n_cmp = 0; n_bad = 0; cyc = 0; n_wv = 0; n_rreq = 0; n_rise = 0;
    rreq_cyc = 0; oe_rise_cyc = 0; exp_err = 0;
    rn = 1'b0; h_oe = 1'b1; h_val = 1'b1; bus.rdata = '0;
    tick(3);
    chk("rst_wvalid", 64'(bus.wvalid), 64'(0));
    chk("rst_rreq", 64'(bus.rreq), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_wdata", 64'(bus.wdata), 64'(0));
    chk("rst_err_cnt", 64'(bus.err_cnt), 64'(0));
    chk("rst_oe", 64'(dut.oe_q), 64'(0));
    rn = 1'b1;
    tick(2);

    // Plain write frame
    send_frame(40'h00_1234_5678, 2);
    tick(4);
    chk("write_busy_low", 64'(bus.busy), 64'(0));
    chk("write_pulses", 64'(n_wv), 64'(1));

    // Read frame with response
    bus.rdata = 32'hDEADBEEF;
    send_frame(40'h80_0000_0010, 0);
    wait_idle();
    chk("read_pulses", 64'(n_rreq), 64'(1));
    chk("read_responses", 64'(n_rise), 64'(1));

    // One-clock glitch in idle: false start
    k = n_wv + n_rreq;
    h_val = 1'b0;
    tick(1);
    h_val = 1'b1;
    tick(12);
    exp_err += ERR_EN;
    chk("false_start_no_frame", 64'(n_wv + n_rreq), 64'(k));
    chk("false_start_err_cnt", 64'(bus.err_cnt), 64'(exp_err));
    chk("false_start_idle", 64'(bus.busy), 64'(0));

    // Collision glitch during the turnaround window
    bus.rdata = $urandom;
    k = n_rreq;
    f = {1'b1, 39'($urandom)};
    send_frame(f, 0);
    wait_count("collision_rreq", 0, k);
    while (cyc < rreq_cyc + 12) tick(1);
    h_oe = 1'b1;
    h_val = 1'b0;
    tick(1);
    h_oe = 1'b0;
    exp_err += ERR_EN;
    wait_idle();
    chk("collision_err_cnt", 64'(bus.err_cnt), 64'(exp_err));

    // Reset in the 10th response bit
    bus.rdata = $urandom;
    k = n_rise;
    send_frame({1'b1, 39'($urandom)}, 0);
    wait_count("reset_test_rise", 1, k);
    while (cyc < oe_rise_cyc + 9 * OVS) tick(1);
    rn = 1'b0;
    tick(1);
    chk("midrsp_rst_oe", 64'(dut.oe_q), 64'(0));
    chk("midrsp_rst_busy", 64'(bus.busy), 64'(0));
    chk("midrsp_rst_wdata", 64'(bus.wdata), 64'(0));
    chk("midrsp_rst_err", 64'(bus.err_cnt), 64'(0));
    rn = 1'b1;
    exp_err = 0;
    h_oe = 1'b1;
    h_val = 1'b1;
    tick(2);
    k = n_wv;
    send_frame(40'h00_0000_00AA, 2);
    tick(2);
    chk("post_reset_write", 64'(n_wv), 64'(k + 1));

    // Back-to-back writes with a single idle bit between
    k = n_wv;
    send_frame({1'b0, 39'({$urandom, $urandom})}, 1);
    send_frame({1'b0, 39'({$urandom, $urandom})}, 1);
    tick(8);
    chk("b2b_pulses", 64'(n_wv), 64'(k + 2));
    chk("b2b_err_cnt", 64'(bus.err_cnt), 64'(exp_err));

    // Random mix of reads and writes
    for (int i = 0; i < 10; i++) begin
      f = {1'($urandom_range(0, 1)), 39'({$urandom, $urandom})};
      if (f[NBT-1]) begin
        bus.rdata = $urandom;
        send_frame(f, 0);
        wait_idle();
      end else begin
        send_frame(f, $urandom_range(1, 3));
      end
    end
    tick(12);
    chk("frames_outstanding", 64'(exp_q.size()), 64'(0));
    chk("responses_outstanding", 64'(rsp_q.size()), 64'(0));
    chk("final_err_cnt", 64'(bus.err_cnt), 64'(exp_err));
    chk("final_idle", 64'(bus.busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sio_remote.md
Name: sio_remote

Overview:
- Remote (device) end of the single-wire bidirectional SIO link; pairs with the host-side SIO block.
- Receives host frames on sdio: start bit 0, then NBT bits MSB first, line idles high.
- Bit NBT-1 = 0 (write): presents the frame word to local logic.
- Bit NBT-1 = 1 (read): presents the request, waits a turnaround, then drives start bit 0 + NBR response bits + one park-high bit back to the host, then releases the line.

Parameters:
- NBT, 40, host-to-remote payload bits; bit NBT-1 is the read flag.
- NBR, 32, remote-to-host response bits.
- OVS, 4, remote clocks per bit period; must be even and >= 4.
- TA, 10, turnaround in bit periods from the rreq pulse to the response start bit.

Ports:
- c  input  1  clock; all logic on rising edge.
- rn  input  1  reset; synchronous, active-low.
- sdio  inout  1  serial line; driven only while oe=1 (tristate inferred internally); external pull-up.
- wvalid  output  1  one-cycle pulse: write frame received.
- wdata  output  NBT  last received frame; valid when wvalid or rreq is high, held until the next frame completes.
- rreq  output  1  one-cycle pulse: read frame received; wdata carries the request.
- rdata  input  NBR  response word; sampled on the cycle the response start bit is loaded.
- busy  output  1  high in any state except IDLE.
- err_cnt  output  16  error counter (see Optional Feature).

Behaviour:
- Reset (rn=0 at a clock edge):
  - state=IDLE, oe=0, sdo=1; synchronizer and previous-sample registers=1.
  - wvalid=0, rreq=0, busy=0, wdata=0, err_cnt=0.
  - Takes effect on the next edge even mid-frame or mid-response; oe drops in that same cycle.
- Input path: sdio passes through a 2-flop synchronizer to s; edge detect uses s and s_d.
- IDLE:
  - On s_d=1 and s=0: go to START, bit counter cnt=0.
  - While oe=1 the input is ignored.
- START:
  - At cnt=OVS/2-1, sample s.
  - s=1: false start, return to IDLE, error event.
  - s=0: go to DATA with cnt=0 and bit index=0.
- DATA:
  - Sample s each time cnt=OVS-1 (mid-bit), cnt wraps to 0; shift into a NBT-bit register MSB first.
  - After bit NBT-1 is sampled, in the same cycle load wdata from the register.
  - Read flag (wdata[NBT-1]) = 0: pulse wvalid for 1 cycle, go to WAITHI.
  - Read flag = 1: pulse rreq for 1 cycle, go to TURN.
- WAITHI: wait for s=1, then go to IDLE. This prevents a false start when the line is held low.
- TURN:
  - Count exactly TA*OVS cycles from the rreq cycle.
  - Any s=0 seen after the first 2*OVS cycles is a collision error event; the count continues regardless.
  - On the final cycle: load shift register {1'b0, rdata}, set oe=1, go to TX.
- TX:
  - sdo = shift register MSB; the register shifts left every OVS cycles.
  - NBR+1 bit periods total: start bit plus data MSB first.
  - Then go to PARK.
- PARK: sdo=1 for OVS cycles, then oe=0, go to WAITHI.
- wvalid and rreq are never high in the same cycle, and never re-pulse without a new start bit.
- Counters are sized $clog2 of their maximum; no wrap is possible within a state.

Optional Feature:
- Macro: SIO_REMOTE_ERRCNT_EN.
- Defined:
  - err_cnt increments by 1 on each error event (false start, TURN collision).
  - Saturates at 16'hFFFF; cleared only by reset.
  - Two events cannot coincide because they occur in different states.
- Not defined: err_cnt is constant 0 and no counter logic is generated; the port remains.

Test Plan (NBT=40, NBR=32, OVS=4, TA=10; bench drives sdio at 4 clocks/bit):
- Write frame 0x00_1234_5678 -> exactly one wvalid pulse with wdata=0x0012345678; oe stays 0; busy returns low after the line goes high.
- Read frame 0x80_0000_0010 with rdata=0xDEADBEEF -> rreq pulse with wdata=0x8000000010. oe rises exactly 40 clocks after rreq. The bench recovers start bit 0 then 0xDEADBEEF MSB first at 4 clocks/bit, then 1 for 4 clocks; oe then falls.
- sdio low for 1 clock in IDLE (SIO_REMOTE_ERRCNT_EN defined) -> no wvalid/rreq, err_cnt=1, state back to IDLE. Without the macro, err_cnt stays 0.
- Bench drives sdio low 12 clocks into TURN of a read (macro defined) -> err_cnt increments once; the response is still sent at the exact 40-clock point.
- rn=0 for 1 clock at the 10th response bit -> oe=0 next edge, busy=0. A following write frame 0x00_0000_00AA gives wvalid with wdata=0xAA.
- Two write frames back-to-back with 1 idle bit between -> two wvalid pulses with the correct wdata each; err_cnt=0.
